// File: rtl/vecacc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vecacc_pkg
// Description : Shared definitions for the vector dot-product/sum responder.
//               Register offsets inside the 128-byte window, STATUS/CTRL bit
//               positions, the FSM state type and a byte-enable merge helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package vecacc_pkg;

    // Register offsets (host_addr[6:0])
    localparam logic [6:0] A_BASE = 7'h00;
    localparam logic [6:0] B_BASE = 7'h20;
    localparam logic [6:0] DOT    = 7'h40;
    localparam logic [6:0] SUMA   = 7'h44;
    localparam logic [6:0] SUMB   = 7'h48;
    localparam logic [6:0] STATUS = 7'h4C;
    localparam logic [6:0] CTRL   = 7'h50;

    // STATUS / CTRL field positions
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int STATUS_IDX_LSB  = 8;
    localparam int STATUS_IDX_W    = 4;
    localparam int CTRL_START_BIT  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Merge a 32-bit write into an existing word, one byte per enable bit.
    function automatic logic [31:0] apply_be(
        input logic [31:0] cur,
        input logic [31:0] wdata,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vecacc_mac.sv
`default_nettype none
// ============================================================================
// Module      : vecacc_mac
// Description : Multiply-accumulate datapath. When enabled, adds the low DW
//               bits of a_i*b_i to the dot accumulator and a_i / b_i to the
//               two sum accumulators (all modulo 2^DW). clr_i has priority
//               and zeroes all three accumulators.
// Ports       : clk_i, rstn_i        clock, async active-low reset
//               clr_i, en_i          clear / accumulate controls
//               a_i, b_i             current operand pair
//               dot_o, suma_o, sumb_o accumulated results
// Revision    : 1.0 - initial release
// ============================================================================
module vecacc_mac #(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] dot_o,
    output logic [DW-1:0] suma_o,
    output logic [DW-1:0] sumb_o
);

    logic [DW-1:0] dot_q,  dot_d;
    logic [DW-1:0] suma_q, suma_d;
    logic [DW-1:0] sumb_q, sumb_d;
    logic [DW-1:0] prod;

    // Self-determined width of DW keeps only the low half of the product.
    assign prod = a_i * b_i;

    always_comb begin
        dot_d  = dot_q;
        suma_d = suma_q;
        sumb_d = sumb_q;
        if (clr_i) begin
            dot_d  = '0;
            suma_d = '0;
            sumb_d = '0;
        end else if (en_i) begin
            dot_d  = dot_q  + prod;
            suma_d = suma_q + a_i;
            sumb_d = sumb_q + b_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dot_q  <= '0;
            suma_q <= '0;
            sumb_q <= '0;
        end else begin
            dot_q  <= dot_d;
            suma_q <= suma_d;
            sumb_q <= sumb_d;
        end
    end

    assign dot_o  = dot_q;
    assign suma_o = suma_q;
    assign sumb_o = sumb_q;

endmodule
`default_nettype wire

// File: rtl/vecacc_responder.sv
`default_nettype none
// ============================================================================
// Module      : vecacc_responder
// Description : Bus responder for the host window at BASE_ADDR. Holds operand
//               vectors A and B, and on a CTRL start computes A.B, sum(A) and
//               sum(B) one element per clock through vecacc_mac.
// Ports       : clk_i, rstn_i   clock, async active-low reset
//               host_req/we/addr/be/wdata  host request side
//               host_ack        combinational accept (in-window requests)
//               host_resp       read-data-valid pulse, 1 cycle after accept
//               host_rdata      read data, held until the next read
//               irq_o           one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module vecacc_responder
    import vecacc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int          VEC_LEN   = 8,
    parameter int          DW        = 32
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [3:0]  host_be,
    input  logic [31:0] host_wdata,
    output logic        host_ack,
    output logic        host_resp,
    output logic [31:0] host_rdata,
    output logic        irq_o
);

    localparam int                IDX_W    = $clog2(VEC_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic             in_window;
    logic             acc_wr;
    logic             acc_rd;
    logic             aligned;
    logic             sel_a;
    logic             sel_b;
    logic [6:0]       offset;
    logic [IDX_W-1:0] elem;
    logic             start_cmd;

    assign offset    = host_addr[6:0];
    assign in_window = (host_addr[31:7] == BASE_ADDR[31:7]);
    assign host_ack  = host_req & in_window;
    assign acc_wr    = host_ack & host_we;
    assign acc_rd    = host_ack & ~host_we;
    assign aligned   = (offset[1:0] == 2'b00);
    assign sel_a     = aligned && (offset[6:5] == A_BASE[6:5]);
    assign sel_b     = aligned && (offset[6:5] == B_BASE[6:5]);
    assign elem      = offset[IDX_W+1:2];
    assign start_cmd = acc_wr && (offset == CTRL) && host_be[0]
                       && host_wdata[CTRL_START_BIT];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [DW-1:0]    a_q [VEC_LEN];
    logic [DW-1:0]    a_d [VEC_LEN];
    logic [DW-1:0]    b_q [VEC_LEN];
    logic [DW-1:0]    b_d [VEC_LEN];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             irq_q, irq_d;
    logic             resp_q, resp_d;
    logic [31:0]      rdata_q, rdata_d;

    // FSM outputs
    logic start;
    logic mac_en;
    logic idx_inc;
    logic finish;

    logic [DW-1:0] dot, suma, sumb;
    logic [31:0]   status_word;
    logic [31:0]   rd_val;
    logic          wr_ok;

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_cmd) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start   = 1'b0;
        mac_en  = 1'b0;
        idx_inc = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: start = start_cmd;
            RUN: begin
                mac_en  = 1'b1;
                // idx parks on the last element so STATUS reports it afterwards
                idx_inc = (idx_q != LAST_IDX);
            end
            DONE:    finish = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    vecacc_mac #(
        .DW (DW)
    ) u_mac (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (start),
        .en_i   (mac_en),
        .a_i    (a_q[idx_q]),
        .b_i    (b_q[idx_q]),
        .dot_o  (dot),
        .suma_o (suma),
        .sumb_o (sumb)
    );

    // Operand writes are dropped for the whole busy window, DONE included.
    assign wr_ok = acc_wr & ~busy_q;

    always_comb begin
        for (int i = 0; i < VEC_LEN; i++) begin
            a_d[i] = a_q[i];
            b_d[i] = b_q[i];
        end
        if (wr_ok && sel_a) begin
            a_d[elem] = apply_be(a_q[elem], host_wdata, host_be);
        end
        if (wr_ok && sel_b) begin
            b_d[elem] = apply_be(b_q[elem], host_wdata, host_be);
        end
    end

    always_comb begin
        status_word                                    = '0;
        status_word[STATUS_BUSY_BIT]                   = busy_q;
        status_word[STATUS_DONE_BIT]                   = done_q;
        status_word[STATUS_IDX_LSB +: STATUS_IDX_W]    = STATUS_IDX_W'(idx_q);
    end

    always_comb begin
        rd_val = '0;
        if (sel_a) begin
            rd_val = a_q[elem];
        end else if (sel_b) begin
            rd_val = b_q[elem];
        end else begin
            case (offset)
                DOT:     rd_val = dot;
                SUMA:    rd_val = suma;
                SUMB:    rd_val = sumb;
                STATUS:  rd_val = status_word;
                default: rd_val = '0;
            endcase
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (start) begin
            idx_d = '0;
        end else if (idx_inc) begin
            idx_d = idx_q + 1'b1;
        end

        busy_d = busy_q;
        done_d = done_q;
        if (start) begin
            busy_d = 1'b1;
            done_d = 1'b0;
        end else if (finish) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end

        irq_d   = finish;
        resp_d  = acc_rd;
        // Read data is captured from pre-edge state, so a STATUS read never
        // sees the effect of a start accepted on the same edge.
        rdata_d = acc_rd ? rd_val : rdata_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            for (int i = 0; i < VEC_LEN; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
            end
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            irq_q   <= irq_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    assign host_resp  = resp_q;
    assign host_rdata = rdata_q;
    assign irq_o      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_vecacc_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vecacc_responder
// Description : Self-checking bench for vecacc_responder. A table of single
//               transactions, hand-written compute/abort sequences and a
//               randomized phase checked against an array-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vecacc_responder;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        clk;
    logic        rstn;
    logic        host_req;
    logic        host_we;
    logic [31:0] host_addr;
    logic [3:0]  host_be;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic        host_resp;
    logic [31:0] host_rdata;
    logic        irq_o;

    vecacc_responder #(
        .BASE_ADDR (BASE),
        .VEC_LEN   (8),
        .DW        (32)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_be    (host_be),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_resp  (host_resp),
        .host_rdata (host_rdata),
        .irq_o      (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int irq_cnt = 0;
    int irq_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (irq_o === 1'b1) begin
            irq_cnt = irq_cnt + 1;
            irq_cyc = cyc;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] m_a [8];
    logic [31:0] m_b [8];
    logic [31:0] m_dot, m_suma, m_sumb, m_status;

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = cur;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin
            m_a[i] = 0;
            m_b[i] = 0;
        end
        m_dot = 0; m_suma = 0; m_sumb = 0; m_status = 0;
    endtask

    task automatic m_wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] be);
        int i;
        i = int'(off) / 4;
        if (off[1:0] == 2'b00 && off < 32'h20) m_a[i] = merge(m_a[i], d, be);
        else if (off[1:0] == 2'b00 && off < 32'h40) m_b[i-8] = merge(m_b[i-8], d, be);
    endtask

    task automatic m_compute();
        m_dot = 0; m_suma = 0; m_sumb = 0;
        for (int i = 0; i < 8; i++) begin
            m_dot  = m_dot + m_a[i] * m_b[i];
            m_suma = m_suma + m_a[i];
            m_sumb = m_sumb + m_b[i];
        end
        m_status = 32'h0000_0702;
    endtask

    // ---------------- checking / bus tasks ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output logic ack, output logic resp,
                       output logic [31:0] rd, output int acc_cyc);
        host_req = 1'b1; host_we = we; host_addr = addr; host_be = be; host_wdata = wd;
        #1 ack = host_ack;
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        resp = host_resp;
        rd   = host_rdata;
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] be,
                      output int tc);
        logic a, r;
        logic [31:0] rd;
        txn(1'b1, BASE + off, be, d, a, r, rd, tc);
        chk($sformatf("wr_ack@%h", off), {31'b0, a}, 32'd1);
    endtask

    task automatic rdc(input string nm, input logic [31:0] off, input logic [31:0] exp);
        logic a, r;
        logic [31:0] rd;
        int tc;
        txn(1'b0, BASE + off, 4'h0, 32'h0, a, r, rd, tc);
        chk({nm, "_ack"}, {31'b0, a}, 32'd1);
        chk({nm, "_resp"}, {31'b0, r}, 32'd1);
        chk(nm, rd, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_irq(input int cnt0, input int t_start);
        for (int k = 0; k < 20 && irq_cnt == cnt0; k++) begin
            @(negedge clk);
            #1;
        end
        chk("irq_seen", {31'b0, (irq_cnt > cnt0)}, 32'd1);
        chk("irq_cycle", 32'(irq_cyc), 32'(t_start + 9));
    endtask

    task automatic chk_results(input string tag);
        rdc({tag, "_dot"},    32'h40, m_dot);
        rdc({tag, "_suma"},   32'h44, m_suma);
        rdc({tag, "_sumb"},   32'h48, m_sumb);
        rdc({tag, "_status"}, 32'h4C, m_status);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_ack;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vq[$];

    function automatic void addv(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                 input logic [31:0] wd, input logic ea, input logic [31:0] er);
        vec_t v;
        v.we = we; v.addr = addr; v.be = be; v.wdata = wd; v.exp_ack = ea; v.exp_rd = er;
        vq.push_back(v);
    endfunction

    localparam logic [31:0] NOM_A [8] = '{1, 2, 3, 4, 8, 7, 6, 5};
    localparam logic [31:0] NOM_B [8] = '{7, 5, 3, 1, 4, 6, 8, 32'hA};

    initial begin
        int T, c0, tc;
        logic a, r;
        logic [31:0] rd;

        host_req = 0; host_we = 0; host_addr = 0; host_be = 0; host_wdata = 0;
        rstn = 1'b0;
        m_reset();
        idle(3);
        rstn = 1'b1;

        // ---- table: reset values, byte enables, ignored writes, window ----
        for (int off = 0; off <= 'h50; off += 4) addv(0, BASE + 32'(off), 4'h0, 0, 1, 0);
        addv(1, BASE + 32'h00, 4'b0011, 32'hFFFF_FFFF, 1, 0);
        addv(0, BASE + 32'h00, 4'h0,    0,             1, 32'h0000_FFFF);
        addv(1, BASE + 32'h2C, 4'b1100, 32'hAABB_CCDD, 1, 0);
        addv(0, BASE + 32'h2C, 4'h0,    0,             1, 32'hAABB_0000);
        addv(1, BASE + 32'h00, 4'b0000, 32'h1234_5678, 1, 0);
        addv(0, BASE + 32'h00, 4'h0,    0,             1, 32'h0000_FFFF);
        addv(1, BASE + 32'h54, 4'hF,    32'h1234_5678, 1, 0);
        addv(0, BASE + 32'h54, 4'h0,    0,             1, 0);
        addv(1, BASE + 32'h40, 4'hF,    32'hDEAD_BEEF, 1, 0);
        addv(0, BASE + 32'h40, 4'h0,    0,             1, 0);
        addv(1, BASE + 32'h50, 4'hF,    32'h0000_0000, 1, 0);
        addv(0, BASE + 32'h4C, 4'h0,    0,             1, 0);
        addv(0, 32'h2000_0080, 4'h0,    0,             0, 0);
        addv(1, 32'h1FFF_FFFC, 4'hF,    32'h1,         0, 0);
        addv(0, 32'h2000_0100, 4'h0,    0,             0, 0);

        foreach (vq[i]) begin
            txn(vq[i].we, vq[i].addr, vq[i].be, vq[i].wdata, a, r, rd, tc);
            chk($sformatf("vec%0d_ack", i), {31'b0, a}, {31'b0, vq[i].exp_ack});
            if (vq[i].we) begin
                chk($sformatf("vec%0d_resp", i), {31'b0, r}, 32'd0);
                if (vq[i].exp_ack) m_wr(vq[i].addr - BASE, vq[i].wdata, vq[i].be);
            end else begin
                chk($sformatf("vec%0d_resp", i), {31'b0, r}, {31'b0, vq[i].exp_ack});
                if (vq[i].exp_ack) chk($sformatf("vec%0d_rdata", i), rd, vq[i].exp_rd);
            end
        end

        // ---- nominal compute with in-progress reads ----
        for (int i = 0; i < 8; i++) begin
            wr(32'(4*i), NOM_A[i], 4'hF, tc);       m_wr(32'(4*i), NOM_A[i], 4'hF);
            wr(32'(32 + 4*i), NOM_B[i], 4'hF, tc);  m_wr(32'(32 + 4*i), NOM_B[i], 4'hF);
        end
        c0 = irq_cnt;
        wr(32'h50, 32'h1, 4'h1, T);
        rdc("run_status_t1", 32'h4C, 32'h0000_0001);
        rdc("run_dot_t2",    32'h40, 32'h0000_0007);
        rdc("run_status_t3", 32'h4C, 32'h0000_0201);
        wait_irq(c0, T);
        m_compute();
        chk("nom_dot_model", m_dot, 32'hCA);
        chk_results("nom");
        rdc("nom_suma_const", 32'h44, 32'h24);
        rdc("nom_sumb_const", 32'h48, 32'h2C);
        txn(1'b1, BASE + 32'h54, 4'hF, 32'h5, a, r, rd, tc);
        chk("hold_resp", {31'b0, r}, 32'd0);
        chk("hold_rdata", rd, 32'h2C);
        idle(3);
        chk("nom_single_irq", 32'(irq_cnt), 32'(c0 + 1));

        // ---- busy protection: late operand write and second start dropped ----
        c0 = irq_cnt;
        wr(32'h50, 32'h1, 4'hF, T);
        rdc("busy_status_t1", 32'h4C, 32'h0000_0001);
        rdc("busy_a0_t2",     32'h00, 32'h1);
        wr(32'h00, 32'h100, 4'hF, tc);
        chk("busy_wr_cycle", 32'(tc), 32'(T + 3));
        wr(32'h50, 32'h1, 4'hF, tc);
        wait_irq(c0, T);
        idle(15);
        chk("busy_single_irq", 32'(irq_cnt), 32'(c0 + 1));
        rdc("busy_a0_kept", 32'h00, 32'h1);
        chk_results("busy");

        // ---- overflow wrap ----
        for (int i = 0; i < 16; i++) begin
            wr(32'(4*i), 32'h0001_0000, 4'hF, tc);
            m_wr(32'(4*i), 32'h0001_0000, 4'hF);
        end
        c0 = irq_cnt;
        wr(32'h50, 32'h1, 4'hF, T);
        wait_irq(c0, T);
        m_compute();
        rdc("ovf_dot",  32'h40, 32'h0);
        rdc("ovf_suma", 32'h44, 32'h0008_0000);
        rdc("ovf_sumb", 32'h48, 32'h0008_0000);

        // ---- abort by reset mid-run ----
        c0 = irq_cnt;
        wr(32'h50, 32'h1, 4'hF, T);
        idle(3);
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
        m_reset();
        chk_results("abort");
        rdc("abort_a0", 32'h00, 32'h0);
        idle(15);
        chk("abort_no_irq", 32'(irq_cnt), 32'(c0));

        // ---- randomized phase against the model ----
        for (int it = 0; it < 6; it++) begin
            for (int op = 0; op < 12; op++) begin
                int sel;
                logic [31:0] off, d;
                logic [3:0] be;
                sel = int'($urandom_range(0, 3));
                d   = $urandom;
                be  = 4'($urandom_range(0, 15));
                case (sel)
                    0: begin
                        off = 32'(4 * $urandom_range(0, 15));
                        wr(off, d, be, tc);
                        m_wr(off, d, be);
                    end
                    1: begin
                        off = 32'(4 * $urandom_range(0, 15));
                        rdc($sformatf("rnd_vec@%h", off), off,
                            off < 32'h20 ? m_a[off/4] : m_b[off/4 - 8]);
                    end
                    2: begin
                        off = 32'h54 + 32'(4 * $urandom_range(0, 10));
                        if (d[0]) wr(off, d, be, tc);
                        else rdc($sformatf("rnd_unmapped@%h", off), off, 32'h0);
                    end
                    default: chk_results("rnd_idle");
                endcase
            end
            c0 = irq_cnt;
            wr(32'h50, 32'h1, 4'hF, T);
            wr(32'(4 * $urandom_range(0, 15)), $urandom, 4'hF, tc);
            wr(32'(4 * $urandom_range(0, 15)), $urandom, 4'hF, tc);
            m_compute();
            wait_irq(c0, T);
            chk_results("rnd_done");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/vecacc_responder.md
Name: vecacc_responder

Overview:
- Memory-mapped bus responder that serves the UDM host bus window at BASE_ADDR (0x2000_0000).
- Holds two 8-entry operand vectors A and B. On a start command it computes, sequentially at one element per clock, the dot product A·B, sum(A) and sum(B).
- The host reads the results and status back over the same bus.
- Sits on the SoC interconnect, on the other end of the write/read transactions the UDM host issues.

Parameters:
- BASE_ADDR, 32'h2000_0000: window base. The window is 128 bytes, matched on host_addr[31:7].
- VEC_LEN, 8: elements per operand vector. Fixed at 8 for this revision.
- DW, 32: element and result width.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- host_req  in  1  transaction request
- host_we  in  1  1 = write, 0 = read
- host_addr  in  32  byte address
- host_be  in  4  write byte enables
- host_wdata  in  32  write data
- host_ack  out  1  request accepted (combinational)
- host_resp  out  1  read data valid pulse
- host_rdata  out  32  read data
- irq_o  out  1  one-cycle pulse on completion

Behaviour:
- Reset (rstn_i low, async): all A/B entries, results, status, count = 0; host_resp=0; host_rdata=0; irq_o=0; FSM to IDLE. Reset asserted mid-computation aborts it with no partial results retained.
- Address map (offset = host_addr[6:0]):
  - 0x00-0x1C: A[0..7], RW.
  - 0x20-0x3C: B[0..7], RW.
  - 0x40: DOT, RO.
  - 0x44: SUMA, RO.
  - 0x48: SUMB, RO.
  - 0x4C: STATUS, RO. bit0 busy, bit1 done, bits[11:8] element index.
  - 0x50: CTRL, WO. Writing with wdata[0]=1 starts a computation.
  - All other offsets: reads return 0, writes are ignored.
- Handshake: host_ack = host_req whenever the address is in the window (no wait states). Out-of-window requests are never acked.
- Writes: take effect on the accepting edge and honour host_be per byte.
- Reads: host_resp=1 and host_rdata valid exactly 1 cycle after acceptance. host_rdata holds its value until the next read. Back-to-back reads are allowed, one per cycle.
- FSM: IDLE -> RUN -> DONE -> IDLE.
  - IDLE: accepted CTRL write with wdata[0]=1 (and be[0]=1) clears DOT/SUMA/SUMB and idx, clears done, sets busy, moves to RUN.
  - RUN: each cycle DOT += A[idx]*B[idx] (low 32 bits of the 64-bit product, modulo 2^32 accumulate), SUMA += A[idx], SUMB += B[idx], idx++. After idx=7 is processed, go to DONE.
  - DONE: one cycle. Clears busy, sets done, pulses irq_o, returns to IDLE.
- Latency: start accepted at edge T. RUN occupies T+1..T+8. done=1 and results stable from T+9.
- While busy:
  - Writes to A/B/CTRL are acked and dropped.
  - A START write is ignored; it is not queued.
  - Reads are served and return the in-progress partial values.
- done is sticky until the next accepted start.
- A read of STATUS in the same cycle as a START write returns the pre-start value.

Decomposition:
- Shared package vecacc_pkg:
  - Register offset localparams (A_BASE, B_BASE, DOT, SUMA, SUMB, STATUS, CTRL).
  - FSM state enum (IDLE, RUN, DONE).
  - STATUS bit positions.
- One natural sub-module, vecacc_mac: a 32-bit multiply-accumulate plus two adders, with clear and enable. Top keeps decode, register file and FSM.

Test Plan:
- Reset: drive rstn_i low, then read 0x00..0x50 -> all read 0. host_resp arrives 1 cycle after each ack.
- Nominal compute:
  - Write A = 1,2,3,4,8,7,6,5 and B = 7,5,3,1,4,6,8,0xA, then write 0x50 = 1.
  - Required: irq_o pulses at T+9.
  - Required: DOT = 0xCA, SUMA = 0x24, SUMB = 0x2C, STATUS = 0x0702 (done=1, busy=0, idx=7).
- Byte enables: write A[0] = 0xFFFF_FFFF with be=4'b0011 after reset -> read A[0] = 0x0000_FFFF.
- Busy protection:
  - Start a computation, then at T+3 write A[0]=0x100 and write 0x50=1.
  - Required: A[0] unchanged, a single irq_o pulse, results identical to the nominal values.
- Overflow wrap: A[i] = B[i] = 0x0001_0000 for all i, then start -> DOT = 0, SUMA = SUMB = 0x0008_0000.
- Abort and out-of-window:
  - Assert rstn_i at T+4 -> all results and STATUS read 0, no irq_o pulse.
  - Access 0x2000_0080 -> no host_ack.
